// File: rtl/sha1_pkg.sv
// rtl/sha1_pkg.sv - shared SHA-1 constants and message-pad state encoding
// Purpose: block/word widths, SHA-1 initial hash values, pad marker word and
//          the message-pad FSM state type. Also used by the compression core.
// Ports:   none (package)
package sha1_pkg;

  localparam int BLOCK_W = 512;
  localparam int WORD_W  = 32;

  localparam logic [31:0] H0 = 32'h6745_2301;
  localparam logic [31:0] H1 = 32'hEFCD_AB89;
  localparam logic [31:0] H2 = 32'h98BA_DCFE;
  localparam logic [31:0] H3 = 32'h1032_5476;
  localparam logic [31:0] H4 = 32'hC3D2_E1F0;

  // Word carrying only the 0x80 terminator byte in its first byte position.
  localparam logic [31:0] PAD_WORD = 32'h8000_0000;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    PAD  = 2'd1,
    EMIT = 2'd2,
    XTRA = 2'd3
  } pad_state_e;

endpackage

// File: rtl/sha1_pad_word.sv
// rtl/sha1_pad_word.sv - formats the final message word of a SHA-1 message
// Purpose: keeps the first 'bytes' bytes of the word (big-endian), zeroes the
//          rest and inserts the 0x80 terminator right after the kept bytes.
//          A full word (bytes >= 4) has no room for the terminator: spill=1.
// Ports:   data  [31:0] in  final message word, first byte in [31:24]
//          bytes [2:0]  in  valid byte count, values above 4 mean 4
//          word  [31:0] out masked word with terminator (or data when spill)
//          spill        out terminator must go into the following word
module sha1_pad_word
  import sha1_pkg::*;
(
  input  logic [WORD_W-1:0] data,
  input  logic [2:0]        bytes,
  output logic [WORD_W-1:0] word,
  output logic              spill
);

  always_comb begin
    word  = data;
    spill = 1'b0;
    case (bytes)
      3'd0:    word = PAD_WORD;
      3'd1:    word = {data[31:24], 24'h80_0000};
      3'd2:    word = {data[31:16], 16'h8000};
      3'd3:    word = {data[31:8], 8'h80};
      default: spill = 1'b1;
    endcase
  end

endmodule

// File: rtl/sha1_msg_pad.sv
// rtl/sha1_msg_pad.sv - SHA-1 message padder: 32-bit word stream in, 512-bit blocks out
// Purpose: collects message words into a 16-word block buffer, appends 0x80,
//          zero fill and the 64-bit big-endian bit length, adding a second
//          block when the length field does not fit.
// Ports:   clk, rst_n (async active-low)
//          in_valid/in_ready/in_data[31:0]/in_last/in_bytes[2:0]  word input
//          blk_valid/blk_ready/blk_data[511:0]                    block output, w0 in MSBs
//          blk_first/blk_last                                     message position flags
module sha1_msg_pad
  import sha1_pkg::*;
#(
  parameter int LEN_W = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WORD_W-1:0]    in_data,
  input  logic                 in_last,
  input  logic [2:0]           in_bytes,
  output logic                 blk_valid,
  input  logic                 blk_ready,
  output logic [BLOCK_W-1:0]   blk_data,
  output logic                 blk_first,
  output logic                 blk_last
);

  pad_state_e        state, state_nxt;
  logic [WORD_W-1:0] w [16];
  logic [3:0]        idx;
  logic [4:0]        mark;       // word index holding 0x80; 16 = next block
  logic [LEN_W-1:0]  bitcnt;
  logic              need_xtra;
  logic              first_q;
  logic              last_q;
  logic              rdy_q;      // holds in_ready low while in reset

  logic [2:0]        nbytes;
  logic [5:0]        add_bits;
  logic [63:0]       len64;
  logic [WORD_W-1:0] last_word;
  logic              spill;
  logic              accept;

  sha1_pad_word u_pad_word (
    .data  (in_data),
    .bytes (in_bytes),
    .word  (last_word),
    .spill (spill)
  );

  assign nbytes    = (in_bytes > 3'd4) ? 3'd4 : in_bytes;
  assign add_bits  = in_last ? {nbytes, 3'b000} : 6'd32;
  assign len64     = 64'(bitcnt);
  assign in_ready  = rdy_q && (state == FILL);
  assign accept    = in_valid && in_ready;
  assign blk_valid = (state == EMIT);
  assign blk_first = blk_valid && first_q;
  assign blk_last  = blk_valid && last_q;

  always_comb begin
    blk_data = '0;
    for (int i = 0; i < 16; i++) begin
      blk_data[BLOCK_W-1-WORD_W*i -: WORD_W] = w[i];
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FILL: if (accept) begin
        if (in_last)           state_nxt = PAD;
        else if (idx == 4'd15) state_nxt = EMIT;
      end
      PAD:  state_nxt = EMIT;
      EMIT: if (blk_ready) state_nxt = need_xtra ? XTRA : FILL;
      XTRA: state_nxt = EMIT;
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FILL;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) w[i] <= '0;
      idx       <= '0;
      mark      <= '0;
      bitcnt    <= '0;
      need_xtra <= 1'b0;
      first_q   <= 1'b1;
      last_q    <= 1'b0;
      rdy_q     <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      case (state)
        FILL: if (accept) begin
          bitcnt <= bitcnt + LEN_W'(add_bits);
          if (!in_last) begin
            w[idx] <= in_data;
            if (idx == 4'd15) begin
              last_q    <= 1'b0;
              need_xtra <= 1'b0;
            end else begin
              idx <= idx + 4'd1;
            end
          end else begin
            w[idx] <= last_word;
            if (spill) begin
              mark <= {1'b0, idx} + 5'd1;
              if (idx != 4'd15) w[idx + 4'd1] <= PAD_WORD;
            end else begin
              mark <= {1'b0, idx};
            end
          end
        end
        PAD: begin
          for (int i = 0; i < 16; i++) begin
            if (5'(i) > mark) w[i] <= '0;
          end
          if (mark <= 5'd13) begin
            // Later assignments override the zero fill for w14/w15.
            w[14]     <= len64[63:32];
            w[15]     <= len64[31:0];
            last_q    <= 1'b1;
            need_xtra <= 1'b0;
          end else begin
            last_q    <= 1'b0;
            need_xtra <= 1'b1;
          end
        end
        EMIT: if (blk_ready) begin
          first_q <= last_q;
          if (!need_xtra) idx <= '0;
          if (last_q) bitcnt <= '0;
        end
        XTRA: begin
          for (int i = 0; i < 16; i++) w[i] <= '0;
          if (mark == 5'd16) w[0] <= PAD_WORD;
          w[14]     <= len64[63:32];
          w[15]     <= len64[31:0];
          last_q    <= 1'b1;
          need_xtra <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
